// File: rtl/response_encoder_if.sv
// Result/transmit bus bundle for response_encoder.
//   res_valid/res_data/res_opcode : ALU result strobe and payload
//   res_ready                     : result queue has room
//   tx_start/tx_data              : one-cycle byte request toward the UART
//   tx_busy                       : UART transmitter busy flag
// master = ALU/UART side, slave = encoder side.
interface response_encoder_if;
  logic       res_valid;
  logic [7:0] res_data;
  logic [1:0] res_opcode;
  logic       res_ready;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (
    output res_valid, res_data, res_opcode, tx_busy,
    input  res_ready, tx_start, tx_data
  );

  modport slave (
    input  res_valid, res_data, res_opcode, tx_busy,
    output res_ready, tx_start, tx_data
  );
endinterface

// File: rtl/response_encoder.sv
// Queues ALU results and serialises each one to the UART as a 4-byte frame:
// HEADER, {6'b0, opcode}, result, XOR checksum of the first three bytes.
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low
//   bus        : response_encoder_if.slave (result input + UART byte output)
//   overflow   : sticky, a result arrived while the queue was full
//   frame_busy : a frame is in progress
module response_encoder #(
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  response_encoder_if.slave         bus,
  output logic                      overflow,
  output logic                      frame_busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IDX_W = 2;

  typedef struct packed {
    logic [1:0] opcode;
    logic [7:0] result;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  entry_t             frame_q, frame_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               overflow_q, overflow_d;
  logic               frame_busy_q, frame_busy_d;
  logic               res_ready_q, res_ready_d;
  entry_t             mem_q [FIFO_DEPTH];

  logic               full_c;
  logic               push_c;
  logic               pop_c;

  // Byte i of the frame built from one queue entry.
  function automatic logic [7:0] frame_byte(input entry_t f, input logic [IDX_W-1:0] i);
    logic [7:0] op_byte;
    op_byte = {6'b0, f.opcode};
    case (i)
      2'd0:    frame_byte = HEADER;
      2'd1:    frame_byte = op_byte;
      2'd2:    frame_byte = f.result;
      default: frame_byte = HEADER ^ op_byte ^ f.result;
    endcase
  endfunction

  // Queue bookkeeping; fullness uses the pre-edge count so a same-cycle pop
  // never rescues a result that arrives while full.
  always_comb begin
    full_c      = (count_q == CNT_W'(FIFO_DEPTH));
    push_c      = bus.res_valid && !full_c;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (bus.res_valid & full_c);
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    res_ready_d = (count_d < CNT_W'(FIFO_DEPTH));
  end

  // Frame sequencer: next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_d      = frame_q;
    pop_c        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        pop_c   = 1'b1;
        frame_d = mem_q[rd_ptr_q];
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus.tx_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (idx_q == IDX_W'(3)) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SEND;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // tx_data only changes on entry to SEND, so it is stable for the whole byte.
    tx_start_d   = (state_d == S_SEND);
    tx_data_d    = (state_d == S_SEND) ? frame_byte(frame_d, idx_d) : tx_data_q;
    frame_busy_d = (state_d != S_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      idx_q        <= '0;
      frame_q      <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      overflow_q   <= 1'b0;
      frame_busy_q <= 1'b0;
      res_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      overflow_q   <= overflow_d;
      frame_busy_q <= frame_busy_d;
      res_ready_q  <= res_ready_d;
    end
  end

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= '{opcode: bus.res_opcode, result: bus.res_data};
  end

  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.res_ready = res_ready_q;
  assign overflow      = overflow_q;
  assign frame_busy    = frame_busy_q;

endmodule

// File: tb/tb_response_encoder.sv
module tb_response_encoder;

  logic clk = 1'b0;
  logic reset;
  logic overflow;
  logic frame_busy;

  response_encoder_if bus ();

  response_encoder #(
    .HEADER     (8'hA5),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .overflow   (overflow),
    .frame_busy (frame_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sb_q [$];
  int         start_cnt      = 0;
  int         last_start_cyc = 0;
  logic [7:0] prev_data      = 8'h00;

  bit uart_hold = 1'b0;
  int busy_cnt  = 0;
  bit arm       = 1'b0;

  // UART model: busy rises one cycle after tx_start and stays high 10 cycles;
  // uart_hold forces busy high.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (arm) begin
        arm      = 1'b0;
        busy_cnt = 10;
      end
      if (bus.tx_start) arm = 1'b1;
      if (busy_cnt > 0) begin
        bus.tx_busy = 1'b1;
        busy_cnt--;
      end else begin
        bus.tx_busy = uart_hold;
      end
    end
  end

  // Scoreboard consumer: every tx_start pops one expected byte; tx_data may
  // only change together with a tx_start.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_data = 8'h00;
      end else begin
        if (bus.tx_start) begin
          start_cnt++;
          last_start_cyc = cyc;
          n_checks++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_tx_start: got tx_data=%h, required no tx_start (nothing queued)", bus.tx_data);
          end else begin
            exp = sb_q.pop_front();
            if (bus.tx_data !== exp) begin
              n_fail++;
              $display("FAIL tx_byte: got %h, required %h (cycle %0d)", bus.tx_data, exp, cyc);
            end
          end
        end else begin
          n_checks++;
          if (bus.tx_data !== prev_data) begin
            n_fail++;
            $display("FAIL tx_data_stable: got %h, required %h (cycle %0d)", bus.tx_data, prev_data, cyc);
          end
        end
        prev_data = bus.tx_data;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Drive one result for one cycle; caller is just after a negedge.
  task automatic put(input logic [1:0] op, input logic [7:0] r, input bit accept);
    logic [7:0] ob;
    ob = {6'b0, op};
    bus.res_valid  = 1'b1;
    bus.res_opcode = op;
    bus.res_data   = r;
    if (accept) begin
      sb_q.push_back(8'hA5);
      sb_q.push_back(ob);
      sb_q.push_back(r);
      sb_q.push_back(8'hA5 ^ ob ^ r);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !frame_busy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.res_valid  = 1'b0;
    bus.res_opcode = 2'b00;
    bus.res_data   = 8'h00;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b, required 0", bus.tx_start); end
    n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h, required 00", bus.tx_data); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    n_checks++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL reset_frame_busy: got %b, required 0", frame_busy); end
    n_checks++; if (bus.res_ready !== 1'b1) begin n_fail++; $display("FAIL reset_res_ready: got %b, required 1", bus.res_ready); end
    reset = 1'b1;
  endtask

  task automatic test_single_frame();
    int n, s0;
    bit ok;
    s0 = start_cnt;
    n  = cyc;
    sb_q.push_back(8'hA5); sb_q.push_back(8'h02); sb_q.push_back(8'h07); sb_q.push_back(8'hA0);
    put(2'b10, 8'h07, 1'b0);
    bus.res_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL single_first_pulse: got %0d pulses, required 1", start_cnt - s0); end
    n_checks++; if (last_start_cyc !== n + 3) begin n_fail++; $display("FAIL single_latency: got cycle %0d, required %0d", last_start_cyc, n + 3); end
    wait_idle(200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d bytes pending, required 0", sb_q.size()); end
    n_checks++; if (start_cnt - s0 !== 4) begin n_fail++; $display("FAIL single_pulses: got %0d, required 4", start_cnt - s0); end
  endtask

  task automatic test_checksum();
    int s0;
    bit ok;
    s0 = start_cnt;
    sb_q.push_back(8'hA5); sb_q.push_back(8'h00); sb_q.push_back(8'hFF); sb_q.push_back(8'h5A);
    put(2'b00, 8'hFF, 1'b0);
    bus.res_valid = 1'b0;
    wait_idle(200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL checksum_timeout: got %0d bytes pending, required 0", sb_q.size()); end
    n_checks++; if (start_cnt - s0 !== 4) begin n_fail++; $display("FAIL checksum_pulses: got %0d, required 4", start_cnt - s0); end
  endtask

  // Three back-to-back results from empty: the third lands on the LOAD cycle.
  // Two more then exactly fill the queue only if the count stayed at 2.
  task automatic test_push_pop_same_cycle();
    bit ok;
    uart_hold = 1'b1;
    put(2'b01, 8'h11, 1'b1);
    put(2'b10, 8'h22, 1'b1);
    n_checks++; if (frame_busy !== 1'b1) begin n_fail++; $display("FAIL pp_load_busy: got %b, required 1", frame_busy); end
    put(2'b11, 8'h33, 1'b1);
    put(2'b00, 8'h44, 1'b1);
    n_checks++; if (bus.res_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready_count3: got %b, required 1", bus.res_ready); end
    put(2'b01, 8'h55, 1'b1);
    bus.res_valid = 1'b0;
    n_checks++; if (bus.res_ready !== 1'b0) begin n_fail++; $display("FAIL pp_ready_full: got %b, required 0", bus.res_ready); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pp_overflow: got %b, required 0", overflow); end
    repeat (5) @(negedge clk);
    uart_hold = 1'b0;
    wait_idle(1000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL pp_timeout: got %0d bytes pending, required 0", sb_q.size()); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pp_overflow_end: got %b, required 0", overflow); end
  endtask

  task automatic test_overflow();
    int s0;
    bit ok;
    s0 = start_cnt;
    uart_hold = 1'b1;
    for (int i = 1; i <= 6; i++) put(2'b01, 8'(i), i <= 5);
    bus.res_valid = 1'b0;
    n_checks++; if (bus.res_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_res_ready: got %b, required 0", bus.res_ready); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
    repeat (10) @(negedge clk);
    n_checks++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL ovf_held_pulses: got %0d, required 1", start_cnt - s0); end
    uart_hold = 1'b0;
    wait_idle(1500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_timeout: got %0d bytes pending, required 0", sb_q.size()); end
    n_checks++; if (start_cnt - s0 !== 20) begin n_fail++; $display("FAIL ovf_pulses: got %0d, required 20", start_cnt - s0); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
    n_checks++; if (bus.res_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_end: got %b, required 1", bus.res_ready); end
  endtask

  task automatic test_reset_midframe();
    int s0, s1;
    bit seen;
    s0 = start_cnt;
    put(2'b10, 8'hA1, 1'b1);
    put(2'b01, 8'hB2, 1'b1);
    put(2'b11, 8'hC3, 1'b1);
    bus.res_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (start_cnt - s0 >= 2) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_byte1_timeout: got %0d pulses, required 2", start_cnt - s0); end
    reset = 1'b0;
    #1;
    n_checks++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL mid_async_busy: got %b, required 0", frame_busy); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_async_overflow: got %b, required 0", overflow); end
    n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_async_tx_data: got %h, required 00", bus.tx_data); end
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    s1 = start_cnt;
    repeat (80) @(negedge clk);
    n_checks++; if (start_cnt !== s1) begin n_fail++; $display("FAIL mid_no_resend: got %0d pulses, required 0", start_cnt - s1); end
    n_checks++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got %b, required 0", frame_busy); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow: got %b, required 0", overflow); end
    n_checks++; if (bus.res_ready !== 1'b1) begin n_fail++; $display("FAIL mid_res_ready: got %b, required 1", bus.res_ready); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_checksum();
    test_push_pop_same_cycle();
    test_overflow();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/response_encoder.md
RESPONSE_ENCODER -- requirements
Module: response_encoder

Interface
REQ-001 Parameter: HEADER, default 8'hA5, frame start byte.
REQ-002 Parameter: FIFO_DEPTH, default 4, result queue entries (power of two, >=2).
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 res_valid  input  1  one-cycle strobe from ALU start_TX: result available.
REQ-006 res_data  input  8  ALU result, sampled when res_valid=1.
REQ-007 res_opcode  input  2  opcode that produced the result, sampled with res_data.
REQ-008 tx_busy  input  1  UART transmitter busy flag.
REQ-009 tx_start  output  1  one-cycle request to UART transmitter to send tx_data.
REQ-010 tx_data  output  8  byte to transmit.
REQ-011 res_ready  output  1  high when queue not full.
REQ-012 overflow  output  1  sticky flag: a result was dropped.
REQ-013 frame_busy  output  1  high while a frame is in progress (FSM not IDLE).

Function
REQ-014 Response frame SHALL be 4 bytes in order: HEADER, {6'b0, opcode}, result, checksum.
REQ-015 Checksum SHALL be bitwise XOR of bytes 0..2.
REQ-016 Queue SHALL store {opcode, result} pairs FIFO order, FIFO_DEPTH entries, pointers wrap modulo FIFO_DEPTH.
REQ-017 Push: res_valid=1 and count<FIFO_DEPTH at clock edge; entry written, count+1.
REQ-018 Fullness SHALL be judged on count before the edge; res_valid while full SHALL drop the entry and set overflow, even if a pop occurs that cycle.
REQ-019 Simultaneous push (not full) and pop SHALL both occur; count unchanged.
REQ-020 overflow SHALL stay 1 until reset.
REQ-021 res_ready SHALL be registered-count based: 1 iff count<FIFO_DEPTH.
REQ-022 FSM states: IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE.
REQ-023 IDLE: count!=0 -> LOAD; else stay.
REQ-024 LOAD (one cycle): pop head into frame register, byte index=0 -> SEND.
REQ-025 SEND (one cycle): tx_start=1, tx_data=byte[index] -> WAIT_ACK.
REQ-026 WAIT_ACK: stay until tx_busy=1 (already-high tx_busy advances next cycle) -> WAIT_DONE.
REQ-027 WAIT_DONE: stay until tx_busy=0; then index<3 -> index+1, SEND; index=3 -> IDLE.
REQ-028 tx_data SHALL hold the current byte stable from SEND until leaving WAIT_DONE.
REQ-029 tx_start SHALL be high only in SEND; exactly 4 pulses per frame.
REQ-030 Latency: res_valid at cycle N, FIFO empty, FSM IDLE -> tx_start high at cycle N+3.
REQ-031 Frames SHALL be sent whole; no new pop before current frame's 4th byte completes.
REQ-032 res_valid accepted in any FSM state subject to REQ-017/018.

Reset
REQ-033 reset=0 SHALL immediately force: FSM IDLE, count=0, pointers 0, index 0, tx_start=0, tx_data=8'h00, overflow=0, frame_busy=0, res_ready=1.
REQ-034 Reset mid-frame SHALL abort the frame; remaining bytes and queued entries discarded, not resent after release.
REQ-035 First push accepted on first rising edge with reset=1.

Verification
REQ-036 Reset check: assert reset=0 -> all outputs at REQ-033 values; res_ready=1.
REQ-037 Single frame: opcode 2'b10, result 8'h07, tx_busy model rises 1 cycle after tx_start, high 10 cycles -> tx_data sequence A5,02,07,A0; 4 tx_start pulses; first at N+3.
REQ-038 Checksum edge: opcode 2'b00, result 8'hFF -> bytes A5,00,FF,5A.
REQ-039 Overflow: tx_busy held 1, 6 back-to-back res_valid (results 01..06) -> entry 01 popped, 02..05 queued, res_ready=0, 06 dropped, overflow=1; after tx_busy released frames 01..05 emitted in order.
REQ-040 Push/pop same cycle: count=2, res_valid coincident with LOAD -> count stays 2, no overflow, order preserved.
REQ-041 Reset mid-frame: 3 results queued, reset pulsed after byte 1 of frame 1 -> no further tx_start after release, count=0, overflow=0.
